// File: rtl/ser_ld_rx.sv
// ser_ld_rx: serial-to-parallel front end for the rising-edge data latch.
// Three asynchronous wires (serial clock, data, load strobe) are synchronized,
// deglitched and turned into rise events. Bits shift in on serial-clock rises.
// A load rise with exactly DATA_W bits presents the word with a one-cycle strobe.
// Any other load count sets a sticky framing error.
module ser_ld_rx #(
    parameter int DATA_W    = 4,
    parameter int SYNC_W    = 2,
    parameter int FILT_LEN  = 2,
    parameter int MSB_FIRST = 1,
    localparam int CNT_W    = $clog2(DATA_W + 2)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              sclk_i,
    input  logic              sdat_i,
    input  logic              sld_i,
    input  logic              err_clr_i,
    output logic [DATA_W-1:0] data_o,
    output logic              ltch_o,
    output logic [CNT_W-1:0]  cnt_o,
    output logic              err_o
);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DATA_W + 1);

    // Wire index 0 = sclk, 1 = sdat, 2 = sld.
    logic [2:0]        w_in;
    logic [2:0]        w_sync;
    logic [2:0]        w_all_eq;
    logic [SYNC_W-1:0] r_sync [3];
    logic [2:0]        r_filt;
    logic              r_ck_q;
    logic              r_ld_q;

    logic              w_ck_rise;
    logic              w_ld_rise;
    logic              w_dat;

    logic [DATA_W-1:0] r_sr;
    logic [DATA_W-1:0] w_sr_nxt;
    logic [DATA_W-1:0] w_data_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_ltch_nxt;
    logic              w_err_nxt;

    assign w_in = {sld_i, sdat_i, sclk_i};

    // Plain flop chains into the clk_i domain, nothing between stages.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < 3; i++) r_sync[i] <= '0;
        end else begin
            for (int i = 0; i < 3; i++) r_sync[i] <= {r_sync[i][SYNC_W-2:0], w_in[i]};
        end
    end

    // The synchronized value is the last stage of each chain.
    always_comb begin
        w_sync = 3'b000;
        for (int i = 0; i < 3; i++) w_sync[i] = r_sync[i][SYNC_W-1];
    end

    generate
        if (FILT_LEN > 1) begin : g_filt_hist
            logic [FILT_LEN-2:0] r_hist [3];
            logic [FILT_LEN-1:0] w_win  [3];

            // The window is the current synchronized sample plus its history.
            // The window is "stable" when all of its samples agree.
            always_comb begin
                w_all_eq = 3'b000;
                for (int i = 0; i < 3; i++) begin
                    w_win[i]    = {r_hist[i], w_sync[i]};
                    w_all_eq[i] = (&w_win[i]) | ~(|w_win[i]);
                end
            end

            // Keep the last FILT_LEN-1 synchronized samples per wire.
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    for (int i = 0; i < 3; i++) r_hist[i] <= '0;
                end else begin
                    for (int i = 0; i < 3; i++) r_hist[i] <= w_win[i][FILT_LEN-2:0];
                end
            end
        end else begin : g_filt_none
            assign w_all_eq = 3'b111;
        end
    endgenerate

    // Filtered level follows the synchronized value only across a stable window.
    // Delayed copies of the serial-clock and load levels feed rise detection.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_filt <= 3'b000;
            r_ck_q <= 1'b0;
            r_ld_q <= 1'b0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (w_all_eq[i]) r_filt[i] <= w_sync[i];
                else             r_filt[i] <= r_filt[i];
            end
            r_ck_q <= r_filt[0];
            r_ld_q <= r_filt[2];
        end
    end

    assign w_ck_rise = r_filt[0] & ~r_ck_q;
    assign w_ld_rise = r_filt[2] & ~r_ld_q;
    assign w_dat     = r_filt[1];

    // Shift, count, load and error decisions.
    // A load always judges the pre-shift register and count, so a shift in
    // the same cycle starts the next frame.
    always_comb begin
        w_sr_nxt   = r_sr;
        w_data_nxt = data_o;
        w_cnt_nxt  = cnt_o;
        w_ltch_nxt = 1'b0;
        w_err_nxt  = err_o;

        if (w_ck_rise) begin
            if (MSB_FIRST != 0) w_sr_nxt = {r_sr[DATA_W-2:0], w_dat};
            else                w_sr_nxt = {w_dat, r_sr[DATA_W-1:1]};
            if (w_ld_rise)              w_cnt_nxt = CNT_W'(1);
            else if (cnt_o == CNT_MAX)  w_cnt_nxt = cnt_o;
            else                        w_cnt_nxt = cnt_o + CNT_W'(1);
        end else if (w_ld_rise) begin
            w_cnt_nxt = '0;
        end else begin
            w_cnt_nxt = cnt_o;
        end

        if (w_ld_rise && (cnt_o == CNT_FULL)) begin
            w_data_nxt = r_sr;
            w_ltch_nxt = 1'b1;
        end else if (w_ld_rise) begin
            w_err_nxt  = 1'b1;
        end else if (err_clr_i) begin
            w_err_nxt  = 1'b0;
        end else begin
            w_err_nxt  = err_o;
        end
    end

    // Registered state and outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sr   <= '0;
            data_o <= '0;
            ltch_o <= 1'b0;
            cnt_o  <= '0;
            err_o  <= 1'b0;
        end else begin
            r_sr   <= w_sr_nxt;
            data_o <= w_data_nxt;
            ltch_o <= w_ltch_nxt;
            cnt_o  <= w_cnt_nxt;
            err_o  <= w_err_nxt;
        end
    end

endmodule

// File: tb/tb_ser_ld_rx.sv
// Bench for ser_ld_rx. Two instances share the stimulus, one MSB-first and one LSB-first.
// A word-level model predicts every output on every clock.
// Directed literal checks pin the model's key results.
module tb_ser_ld_rx;

    localparam int SW = 2;
    localparam int FL = 2;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       sclk_i = 1'b0;
    logic       sdat_i = 1'b0;
    logic       sld_i = 1'b0;
    logic       err_clr_i = 1'b0;
    logic [3:0] data1, data0;
    logic       ltch1, ltch0, err1, err0;
    logic [2:0] cnt1, cnt0;

    int checks = 0;
    int failures = 0;
    int pulses = 0;
    bit prev_ltch = 1'b0;

    always #5 clk_i = ~clk_i;

    ser_ld_rx #(.DATA_W(4), .SYNC_W(SW), .FILT_LEN(FL), .MSB_FIRST(1)) dut_msb (
        .clk_i(clk_i), .rst_i(rst_i), .sclk_i(sclk_i), .sdat_i(sdat_i), .sld_i(sld_i),
        .err_clr_i(err_clr_i), .data_o(data1), .ltch_o(ltch1), .cnt_o(cnt1), .err_o(err1));

    ser_ld_rx #(.DATA_W(4), .SYNC_W(SW), .FILT_LEN(FL), .MSB_FIRST(0)) dut_lsb (
        .clk_i(clk_i), .rst_i(rst_i), .sclk_i(sclk_i), .sdat_i(sdat_i), .sld_i(sld_i),
        .err_clr_i(err_clr_i), .data_o(data0), .ltch_o(ltch0), .cnt_o(cnt0), .err_o(err0));

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    // Samples captured per edge (index 0 = newest). A filtered level adopts a
    // value once FL consecutive samples, seen SW edges late, agree. The word
    // logic acts one edge after a filtered rise.
    bit [7:0] h_ck = '0, h_dt = '0, h_ld = '0;
    bit f_ck = 0, f_dt = 0, f_ld = 0, fr_ck = 0, fr_ld = 0;
    bit rk, rl, newerr;
    int m_cnt = 0, m_sr1 = 0, m_sr0 = 0, m_d1 = 0, m_d0 = 0, m_err = 0;
    bit m_ltch = 0;

    function automatic bit stable(input bit [7:0] h);
        for (int j = 1; j < FL; j++) if (h[SW-1+j] != h[SW-1]) return 1'b0;
        return 1'b1;
    endfunction

    initial forever begin
        @(posedge clk_i or posedge rst_i);
        if (rst_i) begin
            h_ck = '0; h_dt = '0; h_ld = '0;
            f_ck = 0; f_dt = 0; f_ld = 0; fr_ck = 0; fr_ld = 0;
            m_cnt = 0; m_sr1 = 0; m_sr0 = 0; m_d1 = 0; m_d0 = 0; m_err = 0; m_ltch = 0;
        end else begin
            rk = f_ck & ~fr_ck;
            rl = f_ld & ~fr_ld;
            newerr = 0;
            m_ltch = 0;
            if (rl) begin
                if (m_cnt == 4) begin
                    m_d1 = m_sr1; m_d0 = m_sr0; m_ltch = 1;
                end else newerr = 1;
            end
            if (newerr) m_err = 1;
            else if (err_clr_i) m_err = 0;
            if (rk) begin
                m_sr1 = ((m_sr1 << 1) | int'(f_dt)) & 15;
                m_sr0 = (m_sr0 >> 1) | (int'(f_dt) << 3);
                m_cnt = rl ? 1 : ((m_cnt < 5) ? m_cnt + 1 : 5);
            end else if (rl) m_cnt = 0;
            fr_ck = f_ck;
            fr_ld = f_ld;
            if (stable(h_ck)) f_ck = h_ck[SW-1];
            if (stable(h_dt)) f_dt = h_dt[SW-1];
            if (stable(h_ld)) f_ld = h_ld[SW-1];
            h_ck = {h_ck[6:0], sclk_i};
            h_dt = {h_dt[6:0], sdat_i};
            h_ld = {h_ld[6:0], sld_i};
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            check("data_msb", data1, m_d1);
            check("data_lsb", data0, m_d0);
            check("ltch_msb", ltch1, m_ltch);
            check("ltch_lsb", ltch0, m_ltch);
            check("cnt_msb", cnt1, m_cnt);
            check("cnt_lsb", cnt0, m_cnt);
            check("err_msb", err1, m_err);
            check("err_lsb", err0, m_err);
            check("ltch_consecutive", prev_ltch & ltch1, 0);
            if (ltch1) pulses++;
            prev_ltch = ltch1;
        end else begin
            prev_ltch = 1'b0;
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic send_bits(input logic [7:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            sdat_i = bits[i];
            cyc(4);
            sclk_i = 1'b1;
            cyc(4);
            sclk_i = 1'b0;
            cyc(4);
        end
    endtask

    task automatic do_load();
        sld_i = 1'b1;
        cyc(5);
        sld_i = 1'b0;
        cyc(5);
    endtask

    task automatic clear_err();
        err_clr_i = 1'b1;
        cyc(1);
        err_clr_i = 1'b0;
        cyc(2);
    endtask

    initial begin
        // 1: reset state, then idle
        rst_i = 1'b1;
        cyc(3);
        rst_i = 1'b0;
        @(negedge clk_i);
        check("t1_data", data1, 0);
        check("t1_ltch", ltch1, 0);
        check("t1_cnt", cnt1, 0);
        check("t1_err", err1, 0);
        cyc(10);
        @(negedge clk_i);
        check("t1_idle_cnt", cnt1, 0);
        cyc(1);

        // 2: frame 1,0,1,1 with exact strobe latency
        send_bits(8'b1011, 4);
        @(negedge clk_i);
        check("t2_cnt_before", cnt1, 4);
        cyc(1);
        sld_i = 1'b1;
        repeat (4) @(posedge clk_i);
        @(negedge clk_i);
        check("t2_ltch_early", ltch1, 0);
        @(posedge clk_i);
        @(negedge clk_i);
        check("t2_ltch_on", ltch1, 1);
        check("t2_data", data1, 11);
        @(posedge clk_i);
        @(negedge clk_i);
        check("t2_ltch_off", ltch1, 0);
        check("t2_cnt", cnt1, 0);
        check("t2_err", err1, 0);
        sld_i = 1'b0;
        cyc(5);

        // 3: short frame, clear, overrun frame
        send_bits(8'b101, 3);
        do_load();
        @(negedge clk_i);
        check("t3_short_err", err1, 1);
        check("t3_short_data", data1, 11);
        check("t3_short_cnt", cnt1, 0);
        cyc(1);
        clear_err();
        @(negedge clk_i);
        check("t3_clr", err1, 0);
        cyc(1);
        send_bits(8'b11010, 5);
        @(negedge clk_i);
        check("t3_sat_cnt", cnt1, 5);
        cyc(1);
        do_load();
        @(negedge clk_i);
        check("t3_over_err", err1, 1);
        check("t3_over_data", data1, 11);
        cyc(1);
        clear_err();

        // 4: one-cycle glitches are ignored
        sclk_i = 1'b1; cyc(1); sclk_i = 1'b0; cyc(8);
        sld_i = 1'b1;  cyc(1); sld_i = 1'b0;  cyc(8);
        @(negedge clk_i);
        check("t4_cnt", cnt1, 0);
        check("t4_data", data1, 11);
        check("t4_err", err1, 0);
        cyc(1);

        // 5: load concurrent with first bit of the next frame
        send_bits(8'b0110, 4);
        sdat_i = 1'b1;
        cyc(4);
        sclk_i = 1'b1;
        sld_i = 1'b1;
        cyc(5);
        sclk_i = 1'b0;
        sld_i = 1'b0;
        cyc(6);
        @(negedge clk_i);
        check("t5_data", data1, 6);
        check("t5_cnt", cnt1, 1);
        check("t5_err", err1, 0);

        // 6: LSB-first word, then reset mid-frame
        rst_i = 1'b1;
        cyc(2);
        rst_i = 1'b0;
        cyc(2);
        send_bits(8'b1011, 4);
        do_load();
        @(negedge clk_i);
        check("t6_data_lsb", data0, 13);
        check("t6_data_msb", data1, 11);
        cyc(1);
        send_bits(8'b11, 2);
        rst_i = 1'b1;
        cyc(2);
        @(negedge clk_i);
        check("t6_rst_data", data0, 0);
        check("t6_rst_cnt", cnt0, 0);
        check("t6_rst_ltch", ltch0, 0);
        check("t6_rst_err", err0, 0);
        sdat_i = 1'b0;
        cyc(1);
        rst_i = 1'b0;
        cyc(3);
        send_bits(8'b1100, 4);
        do_load();
        @(negedge clk_i);
        check("t6_after_msb", data1, 12);
        check("t6_after_lsb", data0, 3);
        check("t6_after_cnt", cnt1, 0);
        check("pulse_total", pulses, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
